ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: the sending side of the keyboard link, used to push command bytes to the keyboard (0xED set LEDs, 0xF4 enable, 0xFF reset) over the same open-collector PS2_CLK/PS2_DATA pair the keyboard decoder listens on. It performs the bus request (clock inhibit, start bit), shifts 8 data bits LSB-first plus odd parity and stop on device-generated clock edges, checks the device ACK, and reports done or error. It sits beside the keyboard decoder in the top level. The top level owns the inout pads and drives each pad low when its `*_oe` output is 1, else high-Z.

## Interface
- INHIBIT_CYCLES, 10000, cycles PS2_CLK is held low before the start bit (100 µs at 100 MHz)
- TIMEOUT_CYCLES, 2000000, watchdog limit from start bit to end of frame (20 ms at 100 MHz)
- FILTER_LEN, 4, consecutive equal synchronized samples needed to accept a new PS2_CLK level

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- ps2_clk_in  in  1  PS2_CLK pad level (asynchronous)
- ps2_data_in  in  1  PS2_DATA pad level (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_data_oe  out  1  1 = pull PS2_DATA low
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE; decoder ignores the bus while high
- tx_done  out  1  one-cycle pulse: frame ACKed and bus idle
- tx_err  out  1  one-cycle pulse: NACK or timeout

## Operation
- Input conditioning: both pad inputs pass through a 2-FF synchronizer. PS2_CLK then passes a FILTER_LEN-deep level filter. A falling edge (fall) is a filtered 1→0 transition.
- Accept: on tx_valid && tx_ready, latch shreg = {1'b1 stop, ~^tx_data parity, tx_data}. Clear bit_cnt and watchdog. Go to INHIBIT.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for INHIBIT_CYCLES cycles, then START.
- START: ps2_clk_oe=0, ps2_data_oe=1 (start bit). Watchdog runs. On fall: drive shreg[0] (ps2_data_oe = ~shreg[0]), shift, bit_cnt=1, go to SHIFT.
- SHIFT: on each fall, drive the next bit and increment bit_cnt. The fall with bit_cnt==9 drives stop, which means ps2_data_oe=0 (released). Go to ACK.
- ACK: on the next fall, sample synchronized ps2_data_in. 0 goes to WAIT_IDLE. 1 is a NACK and goes to FAIL.
- WAIT_IDLE: both synchronized lines high for 1 cycle → tx_done pulse, IDLE.
- FAIL: release both lines, pulse tx_err, go to IDLE.
- Watchdog: counts every cycle in START/SHIFT/ACK/WAIT_IDLE. Reaching TIMEOUT_CYCLES-1 forces FAIL.
- Parity: odd. The parity bit is 1 when tx_data has an even number of ones.
- tx_valid while busy is ignored. There is no queue.
- Outputs never drive a pad high. Released means oe=0.

## Timing
- Reset (async, rst_n=0): state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, tx_done=0, tx_err=0. Lines are released immediately, including mid-frame.
- All outputs are registered.
- Accept cycle N: tx_ready=0 and busy=1 at N+1. ps2_clk_oe=1 from N+1 through N+INHIBIT_CYCLES. ps2_data_oe=1 and ps2_clk_oe=0 at N+INHIBIT_CYCLES+1.
- Edge latency: a pad falling edge is seen as fall 2+FILTER_LEN cycles later. ps2_data_oe updates 1 cycle after fall, well inside the device clock-low half-period (≥30 µs).
- Pulses shorter than FILTER_LEN cycles on PS2_CLK are ignored.
- tx_done and tx_err last exactly 1 cycle, coinciding with the return to tx_ready=1. A new request is accepted in the same cycle.
- Simultaneous fall and watchdog expiry: the timeout wins.

## Configuration
- PS2_TX_RETRY_EN defined: NACK or timeout does not pulse tx_err on the first failure. The latched byte is resent once from INHIBIT, with a 1-bit retry flag that clears on accept. A second failure pulses tx_err. tx_ready stays 0 throughout.
- Undefined: the first failure pulses tx_err and returns to IDLE. The retry flag is not built.

## Test plan
- Send 0xF4 with the device model clocking at 12.5 kHz. Pad bits sampled on rising edges must be start 0, then 0,0,1,0,1,1,1,1, parity 0, stop 1. Model ACKs → one tx_done pulse, no tx_err.
- Send 0xED. The device must sample data 1,0,1,1,0,1,1,1 and parity 1. ps2_clk_oe must be high for exactly 10000 cycles before ps2_data_oe rises.
- Model NACKs 0xFF (data high at the 11th clock). Macro off: tx_err pulse, lines released. Macro on: the frame is resent. Second ACK gives tx_done. Second NACK gives tx_err.
- Model never clocks after start: tx_err at TIMEOUT_CYCLES after START entry. Both oe outputs are 0 the same cycle.
- A 3-cycle low glitch on PS2_CLK in SHIFT produces no bit advance. tx_valid pulsed while busy is ignored: the next frame still carries the original byte.
- Assert rst_n=0 mid-SHIFT: both oe outputs go to 0 asynchronously. After release, tx_ready=1, and a fresh 0x01 frame (parity 0) completes.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, start bit, 8 data + odd parity + stop, device ACK check.
// Optional build macro PS2_TX_RETRY_EN resends the latched byte once after a NACK or timeout.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int FILTER_LEN     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);
   // state     | meaning
   // IDLE      | lines released, ready for a byte
   // INHIBIT   | PS2_CLK held low for INHIBIT_CYCLES
   // START     | PS2_DATA low (start bit), waiting for first device clock
   // SHIFT     | data, parity, stop driven on device falling edges
   // ACK       | waiting for the 11th fall to sample the device ACK
   // WAIT_IDLE | waiting for both lines high
   // FAIL      | NACK or timeout, lines released
   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_ACK, S_WAIT_IDLE, S_FAIL
   } state_t;

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FW = $clog2(FILTER_LEN + 1);

   state_t        state, state_nxt;
   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_filt, fall;
   logic [FW-1:0] filt_cnt;
   logic [9:0]    shreg;
   logic [3:0]    bit_cnt;
   logic [IW-1:0] inh_cnt;
   logic [WW-1:0] wd_cnt;
   logic [7:0]    frame_byte;
   logic          inh_tc, wd_run, wd_exp, shift_now, load_frame;
   logic          clk_oe_nxt, data_oe_nxt, done_nxt, err_nxt, ready_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk_in;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data_in;
         dat_s2 <= dat_s1;
      end
   end

   // A new clock level is taken only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
         fall     <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_cnt <= '0;
            clk_filt <= clk_s2;
            fall     <= clk_filt & ~clk_s2;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign inh_tc     = (inh_cnt == '0);
   assign wd_run     = (state == S_START) || (state == S_SHIFT) ||
                       (state == S_ACK) || (state == S_WAIT_IDLE);
   assign wd_exp     = wd_run && (wd_cnt == '0);
   assign shift_now  = fall && !wd_exp && ((state == S_START) || (state == S_SHIFT));
   assign load_frame = (state_nxt == S_INHIBIT) && (state != S_INHIBIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_ready    <= 1'b1;
         busy        <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
      end else begin
         state       <= state_nxt;
         ps2_clk_oe  <= clk_oe_nxt;
         ps2_data_oe <= data_oe_nxt;
         tx_ready    <= ready_nxt;
         busy        <= ~ready_nxt;
         tx_done     <= done_nxt;
         tx_err      <= err_nxt;
      end
   end

`ifdef PS2_TX_RETRY_EN
   logic       retry_flag;
   logic [7:0] byte_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_flag <= 1'b0;
         byte_q     <= '0;
      end else if ((state == S_IDLE) && tx_valid) begin
         retry_flag <= 1'b0;
         byte_q     <= tx_data;
      end else if ((state == S_FAIL) && (state_nxt == S_INHIBIT)) begin
         retry_flag <= 1'b1;
      end
   end

   assign frame_byte = (state == S_IDLE) ? tx_data : byte_q;
`else
   assign frame_byte = tx_data;
`endif

   // Watchdog preloads TIMEOUT_CYCLES-2 so its terminal count is the cycle the count reaches TIMEOUT_CYCLES-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
         inh_cnt <= '0;
         wd_cnt  <= '0;
      end else if (load_frame) begin
         shreg   <= {1'b1, ~^frame_byte, frame_byte};
         bit_cnt <= '0;
         inh_cnt <= IW'(INHIBIT_CYCLES - 1);
         wd_cnt  <= WW'(TIMEOUT_CYCLES - 2);
      end else begin
         if ((state == S_INHIBIT) && !inh_tc)
            inh_cnt <= inh_cnt - 1'b1;
         if (wd_run && !wd_exp)
            wd_cnt <= wd_cnt - 1'b1;
         if (shift_now) begin
            shreg   <= {1'b1, shreg[9:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (tx_valid) state_nxt = S_INHIBIT;
         S_INHIBIT:   if (inh_tc) state_nxt = S_START;
         S_START:     if (wd_exp) state_nxt = S_FAIL;
                      else if (fall) state_nxt = S_SHIFT;
         S_SHIFT:     if (wd_exp) state_nxt = S_FAIL;
                      else if (fall && (bit_cnt == 4'd9)) state_nxt = S_ACK;
         S_ACK:       if (wd_exp) state_nxt = S_FAIL;
                      else if (fall) state_nxt = dat_s2 ? S_FAIL : S_WAIT_IDLE;
         S_WAIT_IDLE: if (wd_exp) state_nxt = S_FAIL;
                      else if (clk_s2 && dat_s2) state_nxt = S_IDLE;
`ifdef PS2_TX_RETRY_EN
         S_FAIL:      state_nxt = retry_flag ? S_IDLE : S_INHIBIT;
`else
         S_FAIL:      state_nxt = S_IDLE;
`endif
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      clk_oe_nxt  = (state_nxt == S_INHIBIT);
      ready_nxt   = (state_nxt == S_IDLE);
      done_nxt    = (state == S_WAIT_IDLE) && (state_nxt == S_IDLE);
      err_nxt     = (state == S_FAIL) && (state_nxt == S_IDLE);
      data_oe_nxt = 1'b0;
      case (state_nxt)
         S_START:        data_oe_nxt = 1'b1;
         S_SHIFT, S_ACK: data_oe_nxt = shift_now ? ~shreg[0] : ps2_data_oe;
         default:        data_oe_nxt = 1'b0;
      endcase
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on open-collector pads.
// Define PS2_TX_RETRY_EN for both files to exercise the resend behaviour.
module tb_ps2_host_tx;
   localparam int INH  = 200;
   localparam int TMO  = 3000;
   localparam int FL   = 4;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_err;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   int pass_cnt = 0;
   int check_cnt = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int bad_cnt = 0;
   logic done_q = 1'b0;
   logic err_q = 1'b0;

   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_err(tx_err));

   always #5 clk = ~clk;

   // Pulse monitor: counts pulses, flags pulses longer than one cycle or not aligned with tx_ready.
   always @(negedge clk) begin
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_err) err_cnt <= err_cnt + 1;
      if (((tx_done || tx_err) && !tx_ready) || (tx_done && done_q) || (tx_err && err_q))
         bad_cnt <= bad_cnt + 1;
      done_q <= tx_done;
      err_q  <= tx_err;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic wait_start(output bit found);
      found = 1'b0;
      for (int i = 0; i < 2 * INH + 100; i++) begin
         if (ps2_data_oe === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // bits[0]=start, bits[8:1]=data LSB first, bits[9]=parity, bits[10]=stop, all sampled at rising edges.
   task automatic device_frame(input bit ack, input int glitch_at, output logic [10:0] bits, output bit started);
      started = 1'b0;
      bits = 'x;
      for (int i = 0; i < 2 * INH + 100; i++) begin
         if (ps2_clk_in === 1'b1 && ps2_data_in === 1'b0 && ps2_clk_oe === 1'b0) begin
            started = 1'b1;
            break;
         end
         tick();
      end
      if (!started) return;
      repeat (HALF) tick();
      bits[0] = ps2_data_in;
      for (int i = 1; i <= 10; i++) begin
         if (i == glitch_at) begin
            dev_clk_low = 1'b1;
            repeat (3) tick();
            dev_clk_low = 1'b0;
            repeat (HALF) tick();
         end
         dev_clk_low = 1'b1;
         repeat (HALF) tick();
         dev_clk_low = 1'b0;
         bits[i] = ps2_data_in;
         repeat (HALF) tick();
      end
      dev_clk_low  = 1'b1;
      dev_data_low = ack;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      repeat (HALF) tick();
      dev_data_low = 1'b0;
      repeat (4) tick();
   endtask

   task automatic wait_pulse(input int d0, input int e0);
      for (int i = 0; i < 300; i++) begin
         if (done_cnt != d0 || err_cnt != e0) break;
         tick();
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      check_cnt++; if (tx_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", tx_ready); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
      check_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL reset_oe got %b want 00", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
      check_cnt++; if ({tx_done, tx_err} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {tx_done, tx_err}); else pass_cnt++;
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_send_f4();
      logic [10:0] bits;
      bit st;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      send(8'hF4);
      check_cnt++; if ({tx_ready, busy, ps2_clk_oe} !== 3'b011) $display("FAIL accept_flags got %b want 011", {tx_ready, busy, ps2_clk_oe}); else pass_cnt++;
      device_frame(1'b1, 0, bits, st);
      check_cnt++; if (st !== 1'b1) $display("FAIL f4_start got %b want 1", st); else pass_cnt++;
      check_cnt++; if (bits !== 11'b1_0_11110100_0) $display("FAIL f4_bits got %b want %b", bits, 11'b1_0_11110100_0); else pass_cnt++;
      wait_pulse(d0, e0);
      check_cnt++; if (done_cnt - d0 !== 1) $display("FAIL f4_done got %0d want 1", done_cnt - d0); else pass_cnt++;
      check_cnt++; if (err_cnt - e0 !== 0) $display("FAIL f4_err got %0d want 0", err_cnt - e0); else pass_cnt++;
   endtask

   task automatic test_inhibit_ed();
      logic [10:0] bits;
      bit st;
      int n, d0;
      d0 = done_cnt;
      send(8'hED);
      n = 0;
      while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < INH + 50) begin
         n++;
         tick();
      end
      check_cnt++; if (n !== INH) $display("FAIL inhibit_len got %0d want %0d", n, INH); else pass_cnt++;
      check_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) $display("FAIL start_oe got %b want 01", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
      device_frame(1'b1, 0, bits, st);
      check_cnt++; if (bits !== 11'b1_1_11101101_0) $display("FAIL ed_bits got %b want %b", bits, 11'b1_1_11101101_0); else pass_cnt++;
      wait_pulse(d0, err_cnt);
      check_cnt++; if (done_cnt - d0 !== 1) $display("FAIL ed_done got %0d want 1", done_cnt - d0); else pass_cnt++;
   endtask

   task automatic test_nack();
      logic [10:0] bits;
      bit st;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      send(8'hFF);
      device_frame(1'b0, 0, bits, st);
      check_cnt++; if (bits !== 11'b1_1_11111111_0) $display("FAIL ff_bits got %b want %b", bits, 11'b1_1_11111111_0); else pass_cnt++;
`ifdef PS2_TX_RETRY_EN
      check_cnt++; if ({err_cnt - e0, tx_ready} !== {32'd0, 1'b0}) $display("FAIL retry_hold err=%0d ready=%b want 0 0", err_cnt - e0, tx_ready); else pass_cnt++;
      device_frame(1'b1, 0, bits, st);
      check_cnt++; if (bits !== 11'b1_1_11111111_0) $display("FAIL resend_bits got %b want %b", bits, 11'b1_1_11111111_0); else pass_cnt++;
      wait_pulse(d0, e0);
      check_cnt++; if ({done_cnt - d0, err_cnt - e0} !== {32'd1, 32'd0}) $display("FAIL resend_ack done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0); else pass_cnt++;
      d0 = done_cnt; e0 = err_cnt;
      send(8'hFF);
      device_frame(1'b0, 0, bits, st);
      device_frame(1'b0, 0, bits, st);
      check_cnt++; if (st !== 1'b1) $display("FAIL resend_start got %b want 1", st); else pass_cnt++;
      wait_pulse(d0, e0);
`else
      wait_pulse(d0, e0);
`endif
      check_cnt++; if ({done_cnt - d0, err_cnt - e0} !== {32'd0, 32'd1}) $display("FAIL nack_err done=%0d err=%0d want 0 1", done_cnt - d0, err_cnt - e0); else pass_cnt++;
      check_cnt++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) $display("FAIL nack_release got %b want 001", {ps2_clk_oe, ps2_data_oe, tx_ready}); else pass_cnt++;
   endtask

   task automatic test_timeout();
      bit found;
      send(8'h12);
      wait_start(found);
      check_cnt++; if (found !== 1'b1) $display("FAIL to_start got %b want 1", found); else pass_cnt++;
`ifdef PS2_TX_RETRY_EN
      repeat (TMO) tick();
      check_cnt++; if ({tx_err, ps2_clk_oe} !== 2'b01) $display("FAIL to_retry got %b want 01", {tx_err, ps2_clk_oe}); else pass_cnt++;
      wait_start(found);
`endif
      repeat (TMO - 1) tick();
      check_cnt++; if (tx_err !== 1'b0) $display("FAIL to_early got %b want 0", tx_err); else pass_cnt++;
      tick();
      check_cnt++; if ({tx_err, tx_ready, ps2_clk_oe, ps2_data_oe} !== 4'b1100) $display("FAIL to_expire got %b want 1100", {tx_err, tx_ready, ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
      repeat (3) tick();
   endtask

   task automatic test_glitch_busy();
      logic [10:0] bits;
      bit st;
      int d0;
      d0 = done_cnt;
      send(8'h55);
      repeat (5) tick();
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      device_frame(1'b1, 4, bits, st);
      check_cnt++; if (bits !== 11'b1_1_01010101_0) $display("FAIL glitch_bits got %b want %b", bits, 11'b1_1_01010101_0); else pass_cnt++;
      wait_pulse(d0, err_cnt);
      check_cnt++; if (done_cnt - d0 !== 1) $display("FAIL glitch_done got %0d want 1", done_cnt - d0); else pass_cnt++;
      repeat (5) tick();
      check_cnt++; if ({tx_ready, ps2_clk_oe} !== 2'b10) $display("FAIL no_queue got %b want 10", {tx_ready, ps2_clk_oe}); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [10:0] bits;
      bit st;
      int d0;
      d0 = done_cnt;
      send(8'h3C);
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      device_frame(1'b1, 0, bits, st);
      tx_valid = 1'b0;
      check_cnt++; if (bits !== 11'b1_1_00111100_0) $display("FAIL b2b_first got %b want %b", bits, 11'b1_1_00111100_0); else pass_cnt++;
      check_cnt++; if ({done_cnt - d0, busy, ps2_clk_oe} !== {32'd1, 2'b11}) $display("FAIL b2b_accept done=%0d busy=%b clk_oe=%b want 1 1 1", done_cnt - d0, busy, ps2_clk_oe); else pass_cnt++;
      device_frame(1'b1, 0, bits, st);
      check_cnt++; if (bits !== 11'b1_1_11000011_0) $display("FAIL b2b_second got %b want %b", bits, 11'b1_1_11000011_0); else pass_cnt++;
      wait_pulse(d0 + 1, err_cnt);
      check_cnt++; if (done_cnt - d0 !== 2) $display("FAIL b2b_done got %0d want 2", done_cnt - d0); else pass_cnt++;
   endtask

   task automatic test_reset_mid_shift();
      logic [10:0] bits;
      bit found, st;
      int d0;
      send(8'h80);
      wait_start(found);
      repeat (HALF) tick();
      for (int i = 0; i < 3; i++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) tick();
         dev_clk_low = 1'b0;
         repeat (HALF) tick();
      end
      check_cnt++; if ({busy, ps2_data_oe} !== 2'b11) $display("FAIL mid_shift got %b want 11", {busy, ps2_data_oe}); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      check_cnt++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL async_release got %b want 00", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check_cnt++; if ({tx_ready, busy} !== 2'b10) $display("FAIL post_reset got %b want 10", {tx_ready, busy}); else pass_cnt++;
      d0 = done_cnt;
      send(8'h01);
      device_frame(1'b1, 0, bits, st);
      check_cnt++; if (bits !== 11'b1_0_00000001_0) $display("FAIL fresh_bits got %b want %b", bits, 11'b1_0_00000001_0); else pass_cnt++;
      wait_pulse(d0, err_cnt);
      check_cnt++; if (done_cnt - d0 !== 1) $display("FAIL fresh_done got %0d want 1", done_cnt - d0); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_send_f4();
      test_inhibit_ed();
      test_nack();
      test_timeout();
      test_glitch_busy();
      test_back_to_back();
      test_reset_mid_shift();
      check_cnt++; if (bad_cnt !== 0) $display("FAIL pulse_shape got %0d bad pulses want 0", bad_cnt); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1);
   end
endmodule
